// File: rtl/kul_seq_divider.sv
// Sequential radix-2 restoring divider for unsigned operands, one quotient bit per clock.
// Define KUL_DIV_APPROX_EN to skip the low TRUNC quotient bits (shorter latency, R driven 0).
module kul_seq_divider #(
    parameter int WIDTH = 8,
    parameter int TRUNC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             dz
);

`ifdef KUL_DIV_APPROX_EN
    localparam int NITER = WIDTH - TRUNC;
`else
    localparam int NITER = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;
    logic             valid_q, valid_d;

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] quo_next_s;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = valid_q;
    assign Q         = q_q;
    assign R         = r_q;
    assign dz        = dz_q;

    // One restoring step: the shifted partial remainder is below 2*divisor, so bit WIDTH of the difference is its sign.
    always_comb begin
        shifted_s  = {rem_q, quo_q[WIDTH-1]};
        diff_s     = shifted_s - {1'b0, div_q};
        quo_next_s = {quo_q[WIDTH-2:0], ~diff_s[WIDTH]};
        if (diff_s[WIDTH]) begin
            rem_next_s = shifted_s[WIDTH-1:0];
        end else begin
            rem_next_s = diff_s[WIDTH-1:0];
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (b == {WIDTH{1'b0}}) begin
                        q_d     = {WIDTH{1'b1}};
                        r_d     = a;
                        dz_d    = 1'b1;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        quo_d   = a;
                        div_d   = b;
                        rem_d   = {WIDTH{1'b0}};
                        cnt_d   = {CW{1'b0}};
                        state_d = BUSY;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                quo_d = quo_next_s;
                rem_d = rem_next_s;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NITER - 1)) begin
`ifdef KUL_DIV_APPROX_EN
                    // Only the top NITER quotient bits were computed; the leftover dividend bits shift out.
                    q_d = quo_next_s << TRUNC;
                    r_d = {WIDTH{1'b0}};
`else
                    q_d = quo_next_s;
                    r_d = rem_next_s;
`endif
                    dz_d    = 1'b0;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            quo_q   <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            div_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            q_q     <= {WIDTH{1'b0}};
            r_q     <= {WIDTH{1'b0}};
            dz_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_kul_seq_divider.sv
// Table-driven bench for kul_seq_divider (WIDTH=8, TRUNC=2); follows KUL_DIV_APPROX_EN when defined.
module tb_kul_seq_divider;

    localparam int W = 8;
`ifdef KUL_DIV_APPROX_EN
    localparam int LAT    = 6;
    localparam bit APPROX = 1'b1;
`else
    localparam int LAT    = 8;
    localparam bit APPROX = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = 8'd0;
    logic [W-1:0] b = 8'd0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         dz;

    int n_vec = 0;
    int n_err = 0;

    kul_seq_divider #(.WIDTH(W), .TRUNC(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .Q(Q), .R(R), .dz(dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;   // -1: divide-by-zero, result within one edge of accept
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        chk("idle_in_ready", int'(in_ready), 1);
        @(negedge clk);
        a = v.a; b = v.b; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (v.lat < 0) begin
            chk("dz_latency_le1", int'(lat <= 1), 1);
        end else begin
            chk("latency", lat, v.lat);
        end
        chk("Q", int'(Q), int'(v.q));
        chk("R", int'(R), int'(v.r));
        chk("dz", int'(dz), int'(v.dz));
        @(negedge clk);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_out_valid", int'(out_valid), 0);
        chk("release_in_ready", int'(in_ready), 1);
        chk("hold_Q_after_release", int'(Q), int'(v.q));
    endtask

    initial begin
        vec_t vecs[$];
        logic [W-1:0] q0, r0;
        int lat;

        if (APPROX) begin
            vecs.push_back('{8'd100, 8'd7, 8'd12, 8'd0, 1'b0, LAT});
            vecs.push_back('{8'd200, 8'd7, 8'd28, 8'd0, 1'b0, LAT});
            vecs.push_back('{8'd255, 8'd1, 8'd252, 8'd0, 1'b0, LAT});
            vecs.push_back('{8'd5, 8'd9, 8'd0, 8'd0, 1'b0, LAT});
            vecs.push_back('{8'd77, 8'd0, 8'd255, 8'd77, 1'b1, -1});
        end else begin
            vecs.push_back('{8'd200, 8'd7, 8'd28, 8'd4, 1'b0, LAT});
            vecs.push_back('{8'd5, 8'd9, 8'd0, 8'd5, 1'b0, LAT});
            vecs.push_back('{8'd255, 8'd1, 8'd255, 8'd0, 1'b0, LAT});
            vecs.push_back('{8'd77, 8'd0, 8'd255, 8'd77, 1'b1, -1});
            vecs.push_back('{8'd100, 8'd7, 8'd14, 8'd2, 1'b0, LAT});
            vecs.push_back('{8'd255, 8'd255, 8'd1, 8'd0, 1'b0, LAT});
            vecs.push_back('{8'd0, 8'd5, 8'd0, 8'd0, 1'b0, LAT});
            vecs.push_back('{8'd254, 8'd16, 8'd15, 8'd14, 1'b0, LAT});
        end

        // Reset held for two edges.
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_Q", int'(Q), 0);
        chk("rst_R", int'(R), 0);
        chk("rst_dz", int'(dz), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure, with an ignored operand pulse during BUSY.
        q0 = 8'd28;
        r0 = APPROX ? 8'd0 : 8'd4;
        @(negedge clk);
        a = 8'd200; b = 8'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("busy_in_ready", int'(in_ready), 0);
        @(negedge clk);
        a = 8'd9; b = 8'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("bp_result_reached", int'(out_valid), 1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_Q_stable", int'(Q), int'(q0));
            chk("bp_R_stable", int'(R), int'(r0));
            chk("bp_in_ready_low", int'(in_ready), 0);
            chk("bp_out_valid_high", int'(out_valid), 1);
            tick();
        end
        @(negedge clk);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release", int'(out_valid), 0);
        tick();
        tick();
        chk("bp_no_queued_op", int'(out_valid), 0);
        chk("bp_idle_after", int'(in_ready), 1);

        // Reset asserted at edge N+3 of a divide.
        @(negedge clk);
        a = 8'd200; b = 8'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_Q", int'(Q), 0);
        chk("midrst_R", int'(R), 0);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid) lat++;
        end
        chk("midrst_no_pulse", lat, 0);
        run_vec('{8'd100, 8'd7, APPROX ? 8'd12 : 8'd14, APPROX ? 8'd0 : 8'd2, 1'b0, LAT});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
